// File: rtl/return_addr_stack.sv
// return_addr_stack: JAL/JS return-address stack, circular push-when-full under RAS_WRAP_EN, saturating otherwise
module return_addr_stack #(
  parameter int DEPTH = 8,
  parameter int ADDR_W = 32,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              JAL_signal,
  input  logic              JS_signal,
  input  logic [ADDR_W-1:0] PC_plus_1,
  output logic [ADDR_W-1:0] Return_Addr,
  output logic              Return_Valid,
  output logic [PTR_W-1:0]  Top_Stack,
  output logic [PTR_W:0]    Count,
  output logic              Full,
  output logic              Empty,
  output logic              Overflow,
  output logic              Underflow
);
`ifdef RAS_WRAP_EN
  localparam logic WRAP = 1'b1;
`else
  localparam logic WRAP = 1'b0;
`endif
  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] top_m1, top_nx, waddr;
  logic [PTR_W:0] count_nx;
  logic push_ok, hit, we;
  assign Full = Count == (PTR_W+1)'(DEPTH);
  assign Empty = Count == '0;
  always_comb begin
    top_m1 = Top_Stack - PTR_W'(1);
    hit = JS_signal && !Empty;
    push_ok = JAL_signal && (!Full || WRAP);
    we = JAL_signal && (hit || push_ok);
    waddr = hit ? top_m1 : Top_Stack;
    top_nx = (hit && JAL_signal) ? Top_Stack : hit ? top_m1 : push_ok ? Top_Stack + PTR_W'(1) : Top_Stack;
    count_nx = (hit && JAL_signal) ? Count : hit ? Count - 1'b1 : (push_ok && !Full) ? Count + 1'b1 : Count;
  end
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= PC_plus_1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Top_Stack <= '0;
      Count <= '0;
      Return_Addr <= '0;
      Return_Valid <= 1'b0;
      Overflow <= 1'b0;
      Underflow <= 1'b0;
    end else begin
      Top_Stack <= top_nx;
      Count <= count_nx;
      Return_Valid <= JS_signal;
      if (JS_signal) Return_Addr <= hit ? mem[top_m1] : '0;
      if (JS_signal && Empty) Underflow <= 1'b1;
      if (JAL_signal && !JS_signal && Full && !WRAP) Overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_return_addr_stack.sv
// tb_return_addr_stack: table-driven and directed checks of return_addr_stack at DEPTH 4, RAS_WRAP_EN aware
module tb_return_addr_stack;
`ifdef RAS_WRAP_EN
  localparam bit W = 1'b1;
`else
  localparam bit W = 1'b0;
`endif
  typedef struct {
    logic jal;
    logic js;
    logic [31:0] pc;
    logic [31:0] ret;
    logic valid;
    int cnt;
    int top;
    logic ovf;
    logic unf;
  } vec_t;
  logic clk = 0;
  logic rst_n = 0;
  logic jal = 0;
  logic js = 0;
  logic [31:0] pc = 0;
  logic [31:0] ret;
  logic valid, full, empty, ovf, unf;
  logic [1:0] top;
  logic [2:0] cnt;
  int n_run = 0;
  int n_fail = 0;
  vec_t vq[$];
  return_addr_stack #(.DEPTH(4), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .JAL_signal(jal), .JS_signal(js), .PC_plus_1(pc),
    .Return_Addr(ret), .Return_Valid(valid), .Top_Stack(top), .Count(cnt),
    .Full(full), .Empty(empty), .Overflow(ovf), .Underflow(unf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask
  task automatic add(input logic j, input logic s, input logic [31:0] p, input logic [31:0] r,
                     input logic v, input int c, input int t, input logic o, input logic u);
    vec_t e;
    e.jal = j; e.js = s; e.pc = p; e.ret = r; e.valid = v; e.cnt = c; e.top = t; e.ovf = o; e.unf = u;
    vq.push_back(e);
  endtask
  task automatic step(input logic j, input logic s, input logic [31:0] p);
    jal = j; js = s; pc = p;
    @(negedge clk);
    jal = 0; js = 0;
  endtask
  initial begin
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 0, 0, 0, 1);
    add(1, 0, 'h19, 0, 0, 1, 1, 0, 1);
    add(1, 0, 'h4F, 0, 0, 2, 2, 0, 1);
    add(1, 0, 'h5A, 0, 0, 3, 3, 0, 1);
    add(0, 1, 0, 'h5A, 1, 2, 2, 0, 1);
    add(0, 1, 0, 'h4F, 1, 1, 1, 0, 1);
    add(0, 1, 0, 'h19, 1, 0, 0, 0, 1);
    add(1, 0, 'h10, 'h19, 0, 1, 1, 0, 1);
    add(1, 0, 'h11, 'h19, 0, 2, 2, 0, 1);
    add(1, 0, 'h12, 'h19, 0, 3, 3, 0, 1);
    add(1, 0, 'h13, 'h19, 0, 4, 0, 0, 1);
    add(1, 0, 'h14, 'h19, 0, 4, W ? 1 : 0, !W, 1);
    for (int i = 0; i < 4; i++)
      add(0, 1, 0, W ? 'h14 - i : 'h13 - i, 1, 3 - i, W ? (4 - i) % 4 : 3 - i, !W, 1);
    add(0, 1, 0, 0, 1, 0, W ? 1 : 0, !W, 1);
    add(0, 0, 0, 0, 0, 0, W ? 1 : 0, !W, 1);
    @(negedge clk);
    chk("reset_count", -1, 32'(cnt), 0);
    chk("reset_empty", -1, 32'(empty), 1);
    rst_n = 1;
    foreach (vq[i]) begin
      step(vq[i].jal, vq[i].js, vq[i].pc);
      chk("ret", i, ret, vq[i].ret);
      chk("valid", i, 32'(valid), 32'(vq[i].valid));
      chk("count", i, 32'(cnt), vq[i].cnt);
      chk("top", i, 32'(top), vq[i].top);
      chk("empty", i, 32'(empty), 32'(vq[i].cnt == 0));
      chk("full", i, 32'(full), 32'(vq[i].cnt == 4));
      chk("overflow", i, 32'(ovf), 32'(vq[i].ovf));
      chk("underflow", i, 32'(unf), 32'(vq[i].unf));
    end
    rst_n = 0;
    #1;
    chk("rst_ovf", 100, 32'(ovf), 0);
    chk("rst_unf", 100, 32'(unf), 0);
    @(negedge clk);
    rst_n = 1;
    step(1, 0, 'h20);
    step(1, 1, 'h30);
    chk("pp_ret", 101, ret, 'h20);
    chk("pp_valid", 101, 32'(valid), 1);
    chk("pp_count", 101, 32'(cnt), 1);
    step(0, 1, 0);
    chk("pp_next_ret", 102, ret, 'h30);
    chk("pp_next_count", 102, 32'(cnt), 0);
    chk("pp_unf", 102, 32'(unf), 0);
    step(1, 1, 'h55);
    chk("ppe_ret", 103, ret, 0);
    chk("ppe_valid", 103, 32'(valid), 1);
    chk("ppe_unf", 103, 32'(unf), 1);
    chk("ppe_count", 103, 32'(cnt), 1);
    step(0, 1, 0);
    chk("ppe_pop", 104, ret, 'h55);
    chk("ppe_pop_count", 104, 32'(cnt), 0);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    step(1, 0, 'h40);
    jal = 1; pc = 'h41;
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("async_count", 105, 32'(cnt), 0);
    chk("async_top", 105, 32'(top), 0);
    chk("async_empty", 105, 32'(empty), 1);
    jal = 0;
    @(negedge clk);
    rst_n = 1;
    step(0, 1, 0);
    chk("post_rst_unf", 106, 32'(unf), 1);
    chk("post_rst_ret", 106, ret, 0);
    chk("post_rst_valid", 106, 32'(valid), 1);
    step(0, 0, 0);
    chk("valid_pulse", 107, 32'(valid), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/return_addr_stack.md
# return_addr_stack

Hardware return-address stack (RAS) for the MIPS jump-and-link / jump-to-stack path. It holds the return addresses pushed by JAL and pops them on JS. It consumes the same JAL_signal/JS_signal decode that drives the Stack_Memory top-of-stack pointer update, and owns the actual storage and the registered return target fed back to the PC-select mux. It sits between the decode stage and PC selection.

## Interface
- DEPTH, 8: number of stack entries; power of two, at least 2.
- ADDR_W, 32: width of the stored return address.
- PTR_W, $clog2(DEPTH): pointer width.

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous, active-low.
- JAL_signal  in  1  push request; sampled on the rising clk edge.
- JS_signal  in  1  pop request; sampled on the rising clk edge.
- PC_plus_1  in  ADDR_W  return address to push.
- Return_Addr  out  ADDR_W  popped address; registered.
- Return_Valid  out  1  one-cycle pulse; marks Return_Addr as updated by a pop.
- Top_Stack  out  PTR_W  index of the next free slot (write pointer).
- Count  out  PTR_W+1  number of valid entries, 0..DEPTH.
- Full  out  1  Count == DEPTH.
- Empty  out  1  Count == 0.
- Overflow  out  1  sticky; set by a push while full in non-wrap mode.
- Underflow  out  1  sticky; set by a pop while empty.

## Operation
- Storage: array mem[0..DEPTH-1] of ADDR_W bits. Top valid entry is mem[Top_Stack-1], with modulo-DEPTH pointer arithmetic.
- Idle (neither request): no state change. Return_Valid = 0.
- Push only, not full:
  - mem[Top_Stack] <= PC_plus_1.
  - Top_Stack <= Top_Stack+1 (wraps DEPTH-1 -> 0).
  - Count <= Count+1.
- Pop only, not empty:
  - Return_Addr <= mem[Top_Stack-1].
  - Top_Stack <= Top_Stack-1.
  - Count <= Count-1.
  - Return_Valid <= 1.
- Push and pop together, not empty:
  - Return_Addr <= old top.
  - Top entry overwritten with PC_plus_1.
  - Top_Stack and Count unchanged.
  - Return_Valid <= 1.
- Push and pop together, empty:
  - Underflow is set and Return_Addr <= 0, Return_Valid <= 1.
  - The push proceeds normally, so Count becomes 1.
- Pop when empty: Return_Addr <= 0, Return_Valid <= 1, Underflow <= 1. Pointer and Count unchanged.
- Push when full: behaviour is set by the configuration macro (see Configuration).
- Overflow and Underflow are cleared only by reset.
- Full and Empty are combinational decodes of the registered Count.

## Timing
- Reset (rst_n = 0, asynchronous) forces all of the following immediately:
  - Top_Stack = 0, Count = 0.
  - Return_Addr = 0, Return_Valid = 0.
  - Overflow = 0, Underflow = 0.
  - Empty = 1, Full = 0.
- Memory contents are not reset.
- Reset asserted mid-operation discards any in-flight push or pop. Deassertion is taken synchronously: the first request is honoured on the first rising edge after rst_n rises.
- Pop latency is 1 cycle: the request is sampled at edge N, and Return_Addr/Return_Valid are valid after edge N until edge N+1.
- Return_Addr holds its value until the next pop.
- A push at edge N is visible to a pop at edge N+1. Back-to-back push/pop is supported every cycle with no bubbles.
- There is no handshake: requests are single-cycle strobes and are never stalled.

## Configuration
- RAS_WRAP_EN defined: circular mode.
  - A push while full writes mem[Top_Stack] (the oldest entry) and advances Top_Stack.
  - Count stays at DEPTH; Overflow stays 0.
  - Subsequent pops return the newest DEPTH entries, then underflow.
- RAS_WRAP_EN undefined: saturating mode.
  - A push while full is dropped: no write, no pointer change.
  - Overflow is set to 1.

## Test plan
- Reset then idle: all outputs at their reset values. Pop -> Return_Addr = 0, Return_Valid pulse, Underflow = 1.
- Push 0x19, 0x4F, 0x5A, then pop three times -> Return_Addr sequence 0x5A, 0x4F, 0x19; Count 3 -> 0; Empty = 1.
- DEPTH = 4, push 0x10..0x14 (five pushes):
  - Without RAS_WRAP_EN: Overflow = 1, Count = 4, pops return 0x13, 0x12, 0x11, 0x10.
  - With RAS_WRAP_EN: Overflow = 0, pops return 0x14, 0x13, 0x12, 0x11.
- Push 0x20, then push 0x30 and pop in the same cycle -> Return_Addr = 0x20, Count = 1. The next pop returns 0x30.
- Push 0x40, 0x41, then assert rst_n = 0 mid-cycle -> Count = 0 and Top_Stack = 0 immediately, without waiting for a clock edge. After release, pop -> Underflow = 1.
